// File: rtl/md_sequencer.sv
// md_sequencer: E-stage multiply/divide sequencer that owns HI/LO.
// Results are computed when the operation starts and held in pending registers.
// They are committed to HI/LO only when the modelled latency has elapsed.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,   // busy cycles for MULT/MULTU (1..15)
  parameter int unsigned DIV_CYCLES  = 10   // busy cycles for DIV/DIVU (1..15)
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active-low
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [31:0] pend_hi, pend_hi_nxt;
  logic [31:0] pend_lo, pend_lo_nxt;
  logic [31:0] hi_nxt, lo_nxt;

  // Arithmetic results, all derived from the current operands
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b;
  logic [31:0] uq_mag, ur_mag;
  logic [31:0] sdiv_q, sdiv_r;
  logic [31:0] udiv_q, udiv_r;
  logic        div_zero;

  // Products, plus signed division built on magnitudes so that
  // 0x8000_0000 / -1 wraps to 0x8000_0000 with a zero remainder.
  always_comb begin
    prod_s   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u   = {32'd0, src_a} * {32'd0, src_b};
    div_zero = (src_b == '0);
    mag_a    = src_a[31] ? (32'd0 - src_a) : src_a;
    mag_b    = src_b[31] ? (32'd0 - src_b) : src_b;
    uq_mag   = '0;
    ur_mag   = '0;
    udiv_q   = '0;
    udiv_r   = '0;
    if (!div_zero) begin
      uq_mag = mag_a / mag_b;
      ur_mag = mag_a % mag_b;
      udiv_q = src_a / src_b;
      udiv_r = src_a % src_b;
    end
    sdiv_q = (src_a[31] ^ src_b[31]) ? (32'd0 - uq_mag) : uq_mag;
    sdiv_r = src_a[31] ? (32'd0 - ur_mag) : ur_mag;
    if (div_zero) begin
      sdiv_q = '1;
      sdiv_r = src_a;
      udiv_q = '1;
      udiv_r = src_a;
    end
  end

  // Status and hazard request
  always_comb begin
    busy     = (state == RUN);
    stall_md = md_D & (busy | (start & ~op[2]));
  end

  // Next-state, counter, pending-result and HI/LO update logic
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    hi_nxt      = hi;
    lo_nxt      = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (md_op_t'(op))
            OP_MULT: begin
              pend_hi_nxt = prod_s[63:32];
              pend_lo_nxt = prod_s[31:0];
              count_nxt   = MULT_LOAD;
              state_nxt   = RUN;
            end
            OP_MULTU: begin
              pend_hi_nxt = prod_u[63:32];
              pend_lo_nxt = prod_u[31:0];
              count_nxt   = MULT_LOAD;
              state_nxt   = RUN;
            end
            OP_DIV: begin
              pend_hi_nxt = sdiv_r;
              pend_lo_nxt = sdiv_q;
              count_nxt   = DIV_LOAD;
              state_nxt   = RUN;
            end
            OP_DIVU: begin
              pend_hi_nxt = udiv_r;
              pend_lo_nxt = udiv_q;
              count_nxt   = DIV_LOAD;
              state_nxt   = RUN;
            end
            OP_MTHI: hi_nxt = src_a;
            OP_MTLO: lo_nxt = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        count_nxt = count - 4'd1;
        if (count == 4'd1) begin
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, pending and architectural HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer with default latencies (5/10).
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        md_D;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] m_hi, m_lo;   // expected architectural HI/LO

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .md_D(md_D),
    .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one mul/div op; optionally inject an MTHI start at busy cycle intr.
  task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el, input logic mdd, input int intr);
    op = o; src_a = a; src_b = b; start = 1'b1; md_D = mdd;
    #1;
    check({name, " stall_start"}, {31'd0, stall_md}, {31'd0, mdd});
    step();
    start = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'h0BAD_F00D; op = 3'd7;
    for (int i = 0; i < n; i++) begin
      check({name, " busy_run"}, {31'd0, busy}, 32'd1);
      check({name, " stall_run"}, {31'd0, stall_md}, {31'd0, mdd});
      check({name, " hi_hold"}, hi, m_hi);
      check({name, " lo_hold"}, lo, m_lo);
      if (i == intr) begin
        start = 1'b1; op = 3'd4; src_a = 32'h0000_1234;
      end
      step();
      start = 1'b0; op = 3'd7;
    end
    check({name, " busy_done"}, {31'd0, busy}, 32'd0);
    check({name, " stall_done"}, {31'd0, stall_md}, 32'd0);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
    m_hi = eh; m_lo = el;
    md_D = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd7; src_a = '0; src_b = '0; md_D = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, stall_md}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b1;
    step();

    run_md("mult_neg",   3'd0, 32'hFFFF_FFFD, 32'd5,        5,  32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, -1);
    run_md("multu_ign",  3'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'h0000_0001, 32'h0000_0000, 1'b0, 2);
    run_md("mult_min",   3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000, 1'b0, -1);
    run_md("multu_max",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, -1);
    run_md("divu_7_2",   3'd3, 32'd7,         32'd2,        10, 32'd1,         32'd3,         1'b1, -1);
    run_md("div_m7_2",   3'd2, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
    run_md("div_7_m2",   3'd2, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,        32'hFFFF_FFFD, 1'b0, -1);
    run_md("div_by0",    3'd2, 32'd9,         32'd0,        10, 32'd9,         32'hFFFF_FFFF, 1'b0, -1);
    run_md("divu_by0",   3'd3, 32'hFFFF_FFF0, 32'd0,        10, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, -1);
    run_md("div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,        32'h8000_0000, 1'b0, -1);

    // MTLO with md_D: no stall, visible next cycle, HI untouched
    op = 3'd5; src_a = 32'h0000_A5A5; start = 1'b1; md_D = 1'b1;
    #1;
    check("mtlo stall", {31'd0, stall_md}, 32'd0);
    step();
    start = 1'b0; md_D = 1'b0;
    check("mtlo busy", {31'd0, busy}, 32'd0);
    check("mtlo lo", lo, 32'h0000_A5A5);
    check("mtlo hi", hi, m_hi);
    m_lo = 32'h0000_A5A5;

    // MTHI
    op = 3'd4; src_a = 32'h5A5A_0000; start = 1'b1;
    step();
    start = 1'b0;
    check("mthi hi", hi, 32'h5A5A_0000);
    check("mthi lo", lo, m_lo);
    m_hi = 32'h5A5A_0000;

    // op 6 and 7: no effect
    op = 3'd6; src_a = 32'h1111_1111; start = 1'b1; md_D = 1'b1;
    #1;
    check("nop stall", {31'd0, stall_md}, 32'd0);
    step();
    op = 3'd7;
    step();
    start = 1'b0; md_D = 1'b0;
    check("nop busy", {31'd0, busy}, 32'd0);
    check("nop hi", hi, m_hi);
    check("nop lo", lo, m_lo);

    // Reset during RUN cycle 3: abandoned, nothing committed afterwards
    op = 3'd2; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    step();
    start = 1'b0; op = 3'd7;
    step();
    step();
    check("rst_mid busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid busy", {31'd0, busy}, 32'd0);
    check("rst_mid hi", hi, 32'd0);
    check("rst_mid lo", lo, 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("rst_after busy", {31'd0, busy}, 32'd0);
    check("rst_after hi", hi, 32'd0);
    check("rst_after lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
